// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single Data_Memory: serves one latched request
// at a time (IDLE -> ACCESS -> RESP) with round-robin or fixed priority on conflict.
module dmem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              MemWrite,
    output logic              MemRead,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Write_Data,
    input  logic [DATA_W-1:0] Read_Data
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic              last_q, last_d;
    logic              lat_we_q, lat_we_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              grant_b;
    logic              in_access;

    // On conflict B wins only in round-robin mode and only if A was served last.
    always_comb begin
        grant_b = 1'b0;
        if (a_req && b_req) begin
            grant_b = RR_EN ? (last_q == PORT_A) : 1'b0;
        end else begin
            grant_b = b_req;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    sel_d       = grant_b ? PORT_B : PORT_A;
                    lat_we_d    = grant_b ? b_we : a_we;
                    lat_addr_d  = grant_b ? b_addr : a_addr;
                    lat_wdata_d = grant_b ? b_wdata : a_wdata;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                // Only the winner's read register moves; the other port's result is kept.
                if (!lat_we_q) begin
                    if (sel_q == PORT_B) b_rdata_d = Read_Data;
                    else                 a_rdata_d = Read_Data;
                end
                last_d  = sel_q;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= PORT_A;
            last_q      <= PORT_B;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    // Gating with reset keeps a reset during ACCESS from committing a write.
    assign in_access  = (state_q == ACCESS);
    assign MemWrite   = in_access & lat_we_q & ~reset;
    assign MemRead    = in_access & ~lat_we_q & ~reset;
    assign Mem_Addr   = in_access ? lat_addr_q : '0;
    assign Write_Data = in_access ? lat_wdata_q : '0;

    assign a_ack   = (state_q == RESP) && (sel_q == PORT_A);
    assign b_ack   = (state_q == RESP) && (sel_q == PORT_B);
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: behavioural Data_Memory, expected read
// results queued at issue time and popped on each ack.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [63:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_ack, b_ack, MemWrite, MemRead;
    logic [63:0] a_rdata, b_rdata, Mem_Addr, Write_Data, Read_Data;
    logic        fp_a_ack, fp_b_ack, fp_mw, fp_mr;
    logic [63:0] fp_a_rdata, fp_b_rdata, fp_addr, fp_wdata, fp_rd;

    logic [63:0] mem [16];
    logic [63:0] fp_mem [16];
    logic [63:0] ref_mem [16];

    int total = 0, bad = 0, cyc = 0;
    int mw_cnt = 0, mr_cnt = 0, a_ack_cnt = 0, b_ack_cnt = 0;
    logic [63:0] addr_log[$];
    logic [63:0] wd_log[$];
    int          cyc_log[$];

    typedef struct {bit port; logic [63:0] data;} exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .MemWrite(MemWrite), .MemRead(MemRead), .Mem_Addr(Mem_Addr), .Write_Data(Write_Data),
        .Read_Data(Read_Data)
    );

    dmem_arbiter #(.RR_EN(1'b0)) fp (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(fp_a_ack), .a_rdata(fp_a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(fp_b_ack), .b_rdata(fp_b_rdata),
        .MemWrite(fp_mw), .MemRead(fp_mr), .Mem_Addr(fp_addr), .Write_Data(fp_wdata),
        .Read_Data(fp_rd)
    );

    assign Read_Data = MemRead ? mem[Mem_Addr[3:0]] : '0;
    assign fp_rd     = fp_mr ? fp_mem[fp_addr[3:0]] : '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (MemWrite) mem[Mem_Addr[3:0]] <= Write_Data;
        if (fp_mw) fp_mem[fp_addr[3:0]] <= fp_wdata;
    end

    always @(negedge clk) begin
        if (MemWrite) mw_cnt++;
        if (MemRead) mr_cnt++;
        if (MemWrite || MemRead) begin
            addr_log.push_back(Mem_Addr);
            wd_log.push_back(Write_Data);
            cyc_log.push_back(cyc);
        end
        if (a_ack) a_ack_cnt++;
        if (b_ack) b_ack_cnt++;
    end

    task automatic do_reset();
        reset = 1'b1;
        a_req = 1'b0; b_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Drives one handshake on a port and reports what came back; returns with the FSM in IDLE.
    task automatic run_txn(input bit port, input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                           output int lat, output logic [63:0] rd, output bit got);
        lat = 0; got = 1'b0; rd = '0;
        if (port) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; end
        else      begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; end
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (port ? b_ack : a_ack) begin
                got = 1'b1;
                rd  = port ? b_rdata : a_rdata;
            end
        end
        if (port) b_req = 1'b0; else a_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int lat; logic [63:0] rd; bit got; int mw0, b0; exp_t e;
        do_reset();
        mw0 = mw_cnt; b0 = b_ack_cnt;
        addr_log.delete(); wd_log.delete(); cyc_log.delete();
        run_txn(1'b0, 1'b1, 64'd5, 64'd50, lat, rd, got);
        ref_mem[5] = 64'd50;
        total++; if (!got || lat !== 2) begin bad++; $display("FAIL wr_latency: got %0d (ack=%0d) want 2", lat, got); end
        total++; if (mw_cnt - mw0 !== 1) begin bad++; $display("FAIL wr_pulse: got %0d want 1", mw_cnt - mw0); end
        total++; if (addr_log.size() < 1 || addr_log[0] !== 64'd5 || wd_log[0] !== 64'd50) begin
            bad++; $display("FAIL wr_addr_data: log size %0d, want addr 5 data 50", addr_log.size());
        end
        sb.push_back('{1'b0, ref_mem[5]});
        run_txn(1'b0, 1'b0, 64'd5, 64'd0, lat, rd, got);
        e = sb.pop_front();
        total++; if (!got || lat !== 2) begin bad++; $display("FAIL rd_latency: got %0d want 2", lat); end
        total++; if (rd !== e.data) begin bad++; $display("FAIL rd_data: got %0h want %0h", rd, e.data); end
        total++; if (b_ack_cnt !== b0) begin bad++; $display("FAIL b_ack_quiet: got %0d want %0d", b_ack_cnt, b0); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if (a_ack !== 1'b0 || b_ack !== 1'b0) begin bad++; $display("FAIL rst_ack: got %b%b want 00", a_ack, b_ack); end
        total++; if (MemWrite !== 1'b0 || MemRead !== 1'b0) begin bad++; $display("FAIL rst_ctrl: got %b%b want 00", MemWrite, MemRead); end
        total++; if (Mem_Addr !== 64'd0 || Write_Data !== 64'd0) begin bad++; $display("FAIL rst_bus: got %0h/%0h want 0", Mem_Addr, Write_Data); end
        total++; if (a_rdata !== 64'd0 || b_rdata !== 64'd0) begin bad++; $display("FAIL rst_rdata: got %0h/%0h want 0", a_rdata, b_rdata); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_conflict_rr();
        int n, last_i; exp_t e; logic [63:0] rd;
        do_reset();
        sb.delete();
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{1'b0, ref_mem[5]});
            sb.push_back('{1'b1, ref_mem[10]});
        end
        a_req = 1'b1; a_we = 1'b0; a_addr = 64'd5;
        b_req = 1'b1; b_we = 1'b0; b_addr = 64'd10;
        n = 0; last_i = 0;
        for (int i = 0; i < 20 && n < 4; i++) begin
            @(posedge clk); #1;
            if (a_ack && b_ack) begin
                total++; bad++; $display("FAIL rr_double_ack: both acks high at step %0d", i);
            end else if (a_ack || b_ack) begin
                e  = sb.pop_front();
                rd = b_ack ? b_rdata : a_rdata;
                total++; if (b_ack !== e.port) begin bad++; $display("FAIL rr_order: grant %0d got port %0d want %0d", n, b_ack, e.port); end
                total++; if (rd !== e.data) begin bad++; $display("FAIL rr_data: got %0h want %0h", rd, e.data); end
                if (n > 0) begin
                    total++; if (i - last_i !== 3) begin bad++; $display("FAIL rr_spacing: got %0d want 3", i - last_i); end
                end
                last_i = i; n++;
            end
        end
        total++; if (n !== 4) begin bad++; $display("FAIL rr_count: got %0d want 4", n); end
        a_req = 1'b0; b_req = 1'b0;
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic test_fixed_priority();
        int n_a, lat; bit got_b;
        do_reset();
        a_req = 1'b1; a_we = 1'b0; a_addr = 64'd5;
        b_req = 1'b1; b_we = 1'b0; b_addr = 64'd10;
        n_a = 0; got_b = 1'b0;
        for (int i = 0; i < 20 && n_a < 4; i++) begin
            @(posedge clk); #1;
            if (fp_b_ack) got_b = 1'b1;
            if (fp_a_ack) n_a++;
        end
        a_req = 1'b0;
        total++; if (n_a !== 4) begin bad++; $display("FAIL fp_a_count: got %0d want 4", n_a); end
        total++; if (got_b !== 1'b0) begin bad++; $display("FAIL fp_b_starved: got %0d want 0", got_b); end
        lat = 0;
        for (int i = 0; i < 8 && !got_b; i++) begin
            @(posedge clk); #1;
            lat++;
            if (fp_b_ack) got_b = 1'b1;
        end
        total++; if (!got_b || lat !== 3) begin bad++; $display("FAIL fp_b_after_drop: got lat %0d ack %0d want 3", lat, got_b); end
        b_req = 1'b0;
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic test_read_isolation();
        int lat; logic [63:0] rd; bit got; exp_t e;
        do_reset();
        run_txn(1'b1, 1'b1, 64'd10, 64'd77, lat, rd, got);
        ref_mem[10] = 64'd77;
        total++; if (!got || a_rdata !== 64'd0 || b_rdata !== 64'd0) begin
            bad++; $display("FAIL iso_write: ack %0d a_rdata %0h b_rdata %0h want 1/0/0", got, a_rdata, b_rdata);
        end
        sb.push_back('{1'b0, ref_mem[10]});
        run_txn(1'b0, 1'b0, 64'd10, 64'd0, lat, rd, got);
        e = sb.pop_front();
        total++; if (rd !== e.data) begin bad++; $display("FAIL iso_a_rdata: got %0h want %0h", rd, e.data); end
        total++; if (b_rdata !== 64'd0) begin bad++; $display("FAIL iso_b_rdata: got %0h want 0", b_rdata); end
    endtask

    task automatic test_reset_access();
        int lat, mw0, ac0; logic [63:0] rd; bit got; exp_t e;
        do_reset();
        mw0 = mw_cnt; ac0 = a_ack_cnt;
        a_req = 1'b1; a_we = 1'b1; a_addr = 64'd5; a_wdata = 64'd99;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        total++; if (MemWrite !== 1'b0) begin bad++; $display("FAIL rst_acc_mw: got %b want 0", MemWrite); end
        @(posedge clk); #1;
        a_req = 1'b0; reset = 1'b0;
        repeat (3) @(posedge clk); #1;
        total++; if (a_ack_cnt !== ac0) begin bad++; $display("FAIL rst_acc_ack: got %0d acks want 0", a_ack_cnt - ac0); end
        total++; if (mw_cnt !== mw0) begin bad++; $display("FAIL rst_acc_writes: got %0d want 0", mw_cnt - mw0); end
        sb.push_back('{1'b0, ref_mem[5]});
        run_txn(1'b0, 1'b0, 64'd5, 64'd0, lat, rd, got);
        e = sb.pop_front();
        total++; if (!got || rd !== e.data) begin bad++; $display("FAIL rst_acc_old: got %0h want %0h", rd, e.data); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] addrs [3];
        int k, last_i; exp_t e;
        addrs[0] = 64'd5; addrs[1] = 64'd6; addrs[2] = 64'hA5A5_0000_0000_0006;
        do_reset();
        for (int j = 0; j < 3; j++) sb.push_back('{1'b0, ref_mem[addrs[j][3:0]]});
        addr_log.delete(); wd_log.delete(); cyc_log.delete();
        a_req = 1'b1; a_we = 1'b0; a_addr = addrs[0];
        k = 0; last_i = 0;
        for (int i = 0; i < 20 && k < 3; i++) begin
            @(posedge clk); #1;
            if (a_ack) begin
                e = sb.pop_front();
                total++; if (a_rdata !== e.data) begin bad++; $display("FAIL b2b_data: access %0d got %0h want %0h", k, a_rdata, e.data); end
                if (k > 0) begin
                    total++; if (i - last_i !== 3) begin bad++; $display("FAIL b2b_spacing: got %0d want 3", i - last_i); end
                end
                last_i = i; k++;
                if (k < 3) a_addr = addrs[k]; else a_req = 1'b0;
            end
        end
        a_req = 1'b0;
        @(posedge clk); #1;
        total++; if (k !== 3 || addr_log.size() !== 3) begin
            bad++; $display("FAIL b2b_count: acks %0d accesses %0d want 3/3", k, addr_log.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                total++; if (addr_log[j] !== addrs[j]) begin bad++; $display("FAIL b2b_addr: access %0d got %0h want %0h", j, addr_log[j], addrs[j]); end
            end
            total++; if (cyc_log[1] - cyc_log[0] !== 3 || cyc_log[2] - cyc_log[1] !== 3) begin
                bad++; $display("FAIL b2b_mem_spacing: got %0d/%0d want 3/3", cyc_log[1] - cyc_log[0], cyc_log[2] - cyc_log[1]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        for (int j = 0; j < 16; j++) begin
            mem[j] = '0; fp_mem[j] = '0; ref_mem[j] = '0;
        end
        test_write_read();
        test_reset();
        test_conflict_rr();
        test_fixed_priority();
        test_read_isolation();
        test_reset_access();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single Data_Memory instance between requester A (CPU load/store path) and requester B (DMA/debug loader).
- Latches one request at a time and drives the memory control, address and write-data lines for exactly one cycle.
- Returns a one-cycle ack and a registered read result to the winning requester.
- Round-robin on conflict, so neither port starves.

Parameters:
- ADDR_W, 64, address width, matches Mem_Addr.
- DATA_W, 64, data width, matches Write_Data/Read_Data.
- RR_EN, 1, 1 = round-robin on conflict; 0 = fixed priority, A always wins.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- a_req  input  1  A requests an access; held high until a_ack.
- a_we  input  1  A access type: 1 = write, 0 = read.
- a_addr  input  ADDR_W  A address.
- a_wdata  input  DATA_W  A write data.
- a_ack  output  1  one-cycle completion pulse to A.
- a_rdata  output  DATA_W  A read result, valid while a_ack=1 for a read, held afterwards.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as the A ports, for B.
- MemWrite  output  1  to Data_Memory.
- MemRead  output  1  to Data_Memory.
- Mem_Addr  output  ADDR_W  to Data_Memory.
- Write_Data  output  DATA_W  to Data_Memory.
- Read_Data  input  DATA_W  from Data_Memory; combinational read while MemRead=1.

Behaviour:
- Memory contract: Data_Memory writes Write_Data to Mem_Addr at the rising clk edge when MemWrite=1. It presents Read_Data combinationally when MemRead=1.
- FSM states: IDLE, ACCESS, RESP.
- Registers: state, sel (winner), last (last served port), lat_we, lat_addr, lat_wdata, a_rdata, b_rdata.
- Reset values: state=IDLE; last=B, so A wins the first conflict; latches=0; a_rdata=b_rdata=0; a_ack=b_ack=0; MemWrite=MemRead=0; Mem_Addr=Write_Data=0.
- IDLE:
  - No request: stay in IDLE.
  - Only one req high: that port wins.
  - Both high, RR_EN=1: the port != last wins. RR_EN=0: A wins.
  - On the edge: latch the winner's we/addr/wdata, set sel, go to ACCESS.
- ACCESS, exactly one cycle:
  - MemWrite = lat_we & ~reset.
  - MemRead = ~lat_we & ~reset.
  - Mem_Addr = lat_addr; Write_Data = lat_wdata.
  - Read: the selected port's rdata register captures Read_Data at the edge.
  - Write: the memory is written at the edge and rdata registers are unchanged.
  - Next state is RESP. last is set to sel.
- RESP, one cycle:
  - The selected port's ack = 1; the other ack = 0. Memory controls = 0.
  - Next state is IDLE.
- Outside ACCESS: MemWrite=MemRead=0. Mem_Addr and Write_Data drive 0.
- Latency: req sampled in IDLE at cycle n → memory access in cycle n+1 → ack in cycle n+2. Peak throughput is 1 access per 3 cycles.
- Handshake:
  - Requester keeps req, we, addr and wdata stable until ack.
  - Requester drops req on the edge that samples ack=1.
  - If req is still high in the following IDLE, it is a new transaction.
- Requests arriving while the FSM is busy wait; no loss, no queue beyond the req level.
- Address and data pass through unmodified; no alignment check, full 64-bit width.
- Non-winning rdata is never disturbed.
- Reset mid-operation:
  - Reset asserted in ACCESS suppresses MemWrite/MemRead that cycle, so no memory write occurs.
  - FSM returns to IDLE with all outputs at reset values.
  - Reset in RESP clears the ack on the next edge; the pulse in progress is not extended.
- Simultaneous new req from the loser during RESP: served in the next IDLE. It wins there if the other port also requests, because last points to the previous winner.

Test Plan:
- Single A write then read: A writes 64'd50 to addr 5, then reads addr 5. MemWrite=1 for exactly one cycle at addr 5; a_ack 2 cycles after each req; a_rdata=50 at second ack; b_ack stays 0.
- Conflict round-robin: after reset, A and B both request reads (A addr 5, B addr 10) held continuously. Grant order is A, B, A, B, and ack spacing is 3 cycles.
- Fixed priority: with RR_EN=0 and both requests held, A is always served and B gets no ack until A drops req.
- Read isolation: B writes 64'd77 to addr 10, then A reads addr 10. a_rdata=77 and b_rdata keeps its prior value (0 after reset).
- Reset in ACCESS: A writes 64'd99 to addr 5 and reset is asserted in the ACCESS cycle. MemWrite=0 that cycle, a later read of addr 5 returns the old value (50), and no a_ack is issued.
- Back-to-back same port: A holds req with addr 5, then 6, changed at each ack. Accesses are 3 cycles apart, and each address appears on Mem_Addr for exactly one cycle.
